// File: rtl/hist_bin_dispatcher.sv
// ---------------------------------------------------------------------------
// hist_bin_dispatcher
//
// Takes coincidence events (start channel, end channel, interval) from the
// TDC front end, classifies each one against a runtime-selected channel
// pair and turns it into a histogram bin address around CENTER. In-range
// addresses are queued in a small FIFO. Queued addresses are then issued to
// the histogram memory incrementer one at a time as mem_add strobes. The
// strobe is either a fixed-length pulse (ACK_MODE=0) or is held until
// mem_ack (ACK_MODE=1). Events lost to a full queue and events whose
// address falls outside the histogram are counted in saturating counters.
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   enable         accept new events when 1
//   cfg_ch_a/b     channel pair to correlate
//   start_ch       event start channel   (stable while data_arrived high)
//   end_ch         event end channel     (stable while data_arrived high)
//   interval       event delay in bins   (stable while data_arrived high)
//   data_arrived   event flag from the TDC domain, rising edge = one event
//   mem_ack        incrementer done (used only when ACK_MODE=1)
//   addr           bin address, stable whenever mem_add=1
//   mem_add        increment strobe
//   fifo_level     queued entries, not counting the one being issued
//   drop_count     events lost to a full queue (saturating)
//   range_count    events with an out-of-range address (saturating)
// ---------------------------------------------------------------------------
module hist_bin_dispatcher #(
  parameter int CH_W        = 2,
  parameter int INTERVAL_W  = 6,
  parameter int ADDR_W      = 7,
  parameter int CENTER      = 64,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_MODE    = 0,
  parameter int HOLD_CYCLES = 6
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [CH_W-1:0]                   cfg_ch_a,
  input  logic [CH_W-1:0]                   cfg_ch_b,
  input  logic [CH_W-1:0]                   start_ch,
  input  logic [CH_W-1:0]                   end_ch,
  input  logic [INTERVAL_W-1:0]             interval,
  input  logic                              data_arrived,
  input  logic                              mem_ack,
  output logic [ADDR_W-1:0]                 addr,
  output logic                              mem_add,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic [15:0]                       drop_count,
  output logic [15:0]                       range_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int SUM_W  = ADDR_W + 2;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [2:0]              sync_q, sync_d;
  logic [ADDR_W-1:0]       mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [15:0]             drop_count_q, drop_count_d;
  logic [15:0]             range_count_q, range_count_d;
  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    mem_add_q, mem_add_d;
  logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;

  // -------------------------------------------------------------------------
  // Event detection and classification
  // -------------------------------------------------------------------------
  logic                    rising;
  logic                    hit_ab, hit_ba;
  logic                    classified;
  logic                    out_of_range;
  logic                    cap_valid;
  logic                    range_evt;
  logic signed [SUM_W-1:0] center_s, interval_s, sum_s;

  assign sync_d = {sync_q[1:0], data_arrived};
  assign rising = (sync_q[2:1] == 2'b01);

  always_comb begin
    center_s   = SUM_W'(CENTER);
    interval_s = SUM_W'(interval);
    hit_ab     = (start_ch == cfg_ch_a) && (end_ch == cfg_ch_b);
    hit_ba     = (start_ch == cfg_ch_b) && (end_ch == cfg_ch_a);
    sum_s      = '0;
    // hit_ab is checked first so that cfg_ch_a==cfg_ch_b resolves to the
    // "start before end" rule.
    if (hit_ab) begin
      sum_s = center_s - interval_s;
    end else if (hit_ba) begin
      sum_s = center_s + interval_s;
    end
  end

  // With the extra two bits, a negative result shows in the sign bit and an
  // overflow past the top bin shows in bit ADDR_W.
  assign out_of_range = sum_s[SUM_W-1] | sum_s[ADDR_W];
  assign classified   = rising && enable && (hit_ab || hit_ba);
  assign cap_valid    = classified && !out_of_range;
  assign range_evt    = classified && out_of_range;

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  logic fifo_empty, fifo_full;
  logic pop, push, drop_evt;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop        = (state_q == IDLE) && !fifo_empty;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign push       = cap_valid && (!fifo_full || pop);
  assign drop_evt   = cap_valid && fifo_full && !pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = sum_s[ADDR_W-1:0];
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // Saturating event counters
  // -------------------------------------------------------------------------
  always_comb begin
    drop_count_d  = drop_count_q;
    range_count_d = range_count_q;
    if (drop_evt && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
    if (range_evt && (range_count_q != 16'hFFFF)) begin
      range_count_d = range_count_q + 16'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Issue FSM
  // mem_add is registered, so the first ISSUE cycle after a pop still has
  // mem_add low; the strobe rises on the following edge.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mem_add_d  = mem_add_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        mem_add_d = 1'b0;
        if (pop) begin
          addr_d     = mem_q[rd_ptr_q];
          hold_cnt_d = '0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (!mem_add_q) begin
          mem_add_d = 1'b1;
        end else if (ACK_MODE != 0) begin
          // The ack cycle is the last one with mem_add high.
          if (mem_ack) begin
            mem_add_d = 1'b0;
            state_d   = GAP;
          end
        end else begin
          if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
            mem_add_d = 1'b0;
            state_d   = GAP;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end
      GAP: begin
        mem_add_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        mem_add_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers. The synchroniser resets to all ones so that data_arrived
  // held high through reset release is not seen as a new event.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q        <= 3'b111;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      drop_count_q  <= '0;
      range_count_q <= '0;
      state_q       <= IDLE;
      addr_q        <= '0;
      mem_add_q     <= 1'b0;
      hold_cnt_q    <= '0;
    end else begin
      sync_q        <= sync_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      drop_count_q  <= drop_count_d;
      range_count_q <= range_count_d;
      state_q       <= state_d;
      addr_q        <= addr_d;
      mem_add_q     <= mem_add_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign addr        = addr_q;
  assign mem_add     = mem_add_q;
  assign fifo_level  = level_q;
  assign drop_count  = drop_count_q;
  assign range_count = range_count_q;

endmodule
